// File: rtl/vec_store_seq.sv
// Vector store sequencer: steps the regfile element counter, captures each returned
// element and writes it to data memory under a ready handshake, then pulses done.
module vec_store_seq #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_VLEN  = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          flush,
  input  logic [4:0]    vreg_base,
  input  logic [AW-1:0] base_addr,
  input  logic [31:0]   vlen,
  output logic [4:0]    rf_read_addr2,
  output logic [31:0]   cnt,
  input  logic [DW-1:0] rf_read_data2,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FETCH = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_VLEN);
  localparam logic [31:0] STEP  = 32'(ADDR_STEP);

  state_t        state_r;
  logic [31:0]   k_r;
  logic [31:0]   n_r;
  logic [AW-1:0] base_addr_r;
  logic [31:0]   n_clamp_s;
  logic [AW-1:0] elem_addr_s;

  // Clamp requested length and form the byte address of element k (wraps mod 2^AW)
  always_comb begin
    n_clamp_s   = 32'd0;
    elem_addr_s = base_addr_r + AW'(k_r * STEP);
    if (vlen > MAX_N) begin
      n_clamp_s = MAX_N;
    end else begin
      n_clamp_s = vlen;
    end
  end

  // Sequencer state and all registered outputs; flush behaves as a synchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      k_r           <= 32'd0;
      n_r           <= 32'd0;
      base_addr_r   <= '0;
      rf_read_addr2 <= 5'd0;
      cnt           <= 32'd0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (flush) begin
      state_r       <= S_IDLE;
      k_r           <= 32'd0;
      n_r           <= 32'd0;
      base_addr_r   <= '0;
      rf_read_addr2 <= 5'd0;
      cnt           <= 32'd0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            rf_read_addr2 <= vreg_base;
            base_addr_r   <= base_addr;
            n_r           <= n_clamp_s;
            k_r           <= 32'd0;
            busy          <= 1'b1;
            if (n_clamp_s == 32'd0) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= S_ISSUE;
              cnt     <= 32'd1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state_r <= S_FETCH;
        end
        S_FETCH: begin
          // Regfile data for cnt is valid now, one cycle after cnt was presented
          mem_wdata <= rf_read_data2;
          mem_addr  <= elem_addr_s;
          mem_we    <= 1'b1;
          state_r   <= S_STORE;
        end
        S_STORE: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (k_r == n_r - 32'd1) begin
              state_r <= S_DONE;
              cnt     <= 32'd0;
              done    <= 1'b1;
            end else begin
              k_r     <= k_r + 32'd1;
              cnt     <= k_r + 32'd2;
              state_r <= S_ISSUE;
            end
          end else begin
            state_r <= S_STORE;
          end
        end
        S_DONE: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          cnt           <= 32'd0;
          rf_read_addr2 <= 5'd0;
          state_r       <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          cnt     <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_store_seq.sv
// Bench for vec_store_seq: directed table, randomized runs against a per-element
// write list model, and hand sequences for flush, async reset and start/flush collision.
module tb_vec_store_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [4:0]  vreg_base;
  logic [31:0] base_addr;
  logic [31:0] vlen;
  logic [4:0]  rf_read_addr2;
  logic [31:0] cnt;
  logic [31:0] rf_read_data2;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  logic [31:0] gpr [32];
  logic [4:0]  ridx;

  vec_store_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .vreg_base(vreg_base), .base_addr(base_addr), .vlen(vlen),
    .rf_read_addr2(rf_read_addr2), .cnt(cnt), .rf_read_data2(rf_read_data2),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered regfile read port: returns gpr[addr2 + cnt - 1] one cycle later
  assign ridx = rf_read_addr2 + cnt[4:0] - 5'd1;
  always @(posedge clk) rf_read_data2 <= gpr[ridx];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_raddr"}, 64'(rf_read_addr2), 64'd0);
  endtask

  // One vector store; the model is the list of (base+k*4, gpr[vb+k]) for k < min(vl,8)
  task automatic do_store(input string tag, input logic [4:0] vb, input logic [31:0] ba,
                          input logic [31:0] vl, input int stall_k, input int stall_n,
                          input bit rnd, input int exp_done);
    int n, cyc, wr, stall_left;
    bit fin;
    logic [31:0] ea;
    n = (vl > 32'd8) ? 8 : int'(vl);
    wr = 0; cyc = 0; fin = 1'b0; stall_left = stall_n;
    @(negedge clk);
    start = 1'b1; vreg_base = vb; base_addr = ba; vlen = vl; mem_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      vreg_base = 5'($urandom); base_addr = $urandom; vlen = $urandom % 16;
      if (done) begin
        if (exp_done >= 0) chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
        chk({tag, "_nwrites"}, 64'(wr), 64'(n));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        start = 1'b0;
        fin = 1'b1;
      end else begin
        start = rnd ? ($urandom % 4 == 0) : 1'b0;
        if (busy !== 1'b1) chk({tag, "_busy"}, 64'(busy), 64'd1);
        if (cnt > 32'd8) chk({tag, "_cnt_max"}, 64'(cnt), 64'd8);
        if (n > 0 && rf_read_addr2 !== vb) chk({tag, "_raddr"}, 64'(rf_read_addr2), 64'(vb));
        if (mem_we) begin
          if (wr >= n) begin
            chk({tag, "_extra_write"}, 64'(wr), 64'(n));
          end else begin
            ea = ba + 32'(wr) * 32'd4;
            chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
            chk({tag, "_wdata"}, 64'(mem_wdata), 64'(gpr[vb + 5'(wr)]));
            chk({tag, "_cnt_store"}, 64'(cnt), 64'(wr + 1));
          end
        end
        if (mem_we && wr == stall_k && stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
        end
        if (mem_we && mem_ready) wr++;
        if (cyc > 300) begin
          chk({tag, "_timeout"}, 64'(cyc), 64'd0);
          start = 1'b0;
          fin = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_idle_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_idle_we"}, 64'(mem_we), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  vb;
    logic [31:0] ba;
    logic [31:0] vl;
    int          stall_k;
    int          stall_n;
    int          exp_done;
  } vec_t;

  vec_t tbl [7];

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    vreg_base = 5'd0; base_addr = 32'd0; vlen = 32'd0;
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;

    tbl[0] = '{"basic3",   5'd16, 32'h0000_0100, 32'd3,  -1, 0, 10};
    tbl[1] = '{"vlen0",    5'd8,  32'h0000_0200, 32'd0,  -1, 0, 1};
    tbl[2] = '{"clamp12",  5'd24, 32'h0000_1000, 32'd12, -1, 0, 25};
    tbl[3] = '{"stall4",   5'd16, 32'h0000_0300, 32'd3,  1,  4, 14};
    tbl[4] = '{"wrap",     5'd8,  32'hFFFF_FFFC, 32'd2,  -1, 0, 7};
    tbl[5] = '{"vlen8",    5'd8,  32'h0000_0040, 32'd8,  -1, 0, 25};
    tbl[6] = '{"vlen1",    5'd24, 32'h0000_0010, 32'd1,  -1, 0, 4};

    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_store(tbl[i].name, tbl[i].vb, tbl[i].ba, tbl[i].vl,
               tbl[i].stall_k, tbl[i].stall_n, 1'b0, tbl[i].exp_done);

    for (int i = 0; i < 12; i++)
      do_store("rand", 5'd8 * 5'($urandom_range(1, 3)), $urandom,
               32'($urandom_range(0, 10)), -1, 0, 1'b1, -1);

    // Flush in FETCH of element 2 (cycle 8)
    @(negedge clk);
    start = 1'b1; vreg_base = 5'd16; base_addr = 32'h400; vlen = 32'd4; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("flush_pre_cnt", 64'(cnt), 64'd3);
    chk("flush_pre_we", 64'(mem_we), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_zero("flush");
    repeat (4) begin
      @(negedge clk);
      chk("flush_nodone", 64'({busy, done}), 64'd0);
    end
    do_store("after_flush", 5'd8, 32'h800, 32'd3, -1, 0, 1'b0, 10);

    // Async reset while a write is pending in STORE (cycle 3)
    @(negedge clk);
    start = 1'b1; vreg_base = 5'd24; base_addr = 32'h500; vlen = 32'd3; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_we", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_nodone", 64'({busy, done}), 64'd0);
    end
    do_store("after_rst", 5'd24, 32'h600, 32'd2, -1, 0, 1'b0, 7);

    // Start and flush together in IDLE: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1; vlen = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("collide_busy", 64'(busy), 64'd0);
    chk("collide_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    chk("collide_busy2", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
